// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings: funct3 codes, LSU FSM states, access sizes and byte-lane masks.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H_LO = 4'b0011;
  localparam logic [3:0] MASK_H_HI = 4'b1100;
  localparam logic [3:0] MASK_W    = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_t;

  // BU/HU only exist as loads; every code without a byte/half meaning is a word access.
  function automatic lsu_size_t access_size(input logic store, input logic [2:0] f3);
    if (f3 == F3_W)                          return SZ_W;
    if (f3 == F3_B || (!store && f3 == F3_BU)) return SZ_B;
    if (f3 == F3_H || (!store && f3 == F3_HU)) return SZ_H;
    return SZ_W;
  endfunction

  function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] lo);
    return (sz == SZ_H && lo[0]) || (sz == SZ_W && lo != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store mask and lane replication, load lane select and extension.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  st_mask,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] rd_word,
  output logic [31:0] ld_val
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    st_mask  = MASK_W;
    st_wdata = store_data;
    case (st_size)
      SZ_B: begin
        st_mask  = MASK_B << st_lo;
        st_wdata = {4{store_data[7:0]}};
      end
      SZ_H: begin
        st_mask  = st_lo[1] ? MASK_H_HI : MASK_H_LO;
        st_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_lo)
      2'd1:    lane_b = rd_word[15:8];
      2'd2:    lane_b = rd_word[23:16];
      2'd3:    lane_b = rd_word[31:24];
      default: lane_b = rd_word[7:0];
    endcase
    lane_h = ld_lo[1] ? rd_word[31:16] : rd_word[15:0];
    ld_val = rd_word;
    case (ld_size)
      SZ_B:    ld_val = {{24{ld_signed & lane_b[7]}}, lane_b};
      SZ_H:    ld_val = {{16{ld_signed & lane_h[15]}}, lane_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// RV32I load/store initiator to a word-addressed data memory with a bounded load wait.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses complete without a memory request.
module lsu_mem_initiator
  import rv32i_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_req,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              lsu_done,
  output logic              stall,
  output logic              bus_err,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              misaligned,
`endif
  output logic              mem_request,
  output logic              mem_we_re,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_w_data,
  output logic [3:0]        mem_masking,
  input  logic              mem_valid,
  input  logic [31:0]       mem_r_data
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  lsu_state_t       state;
  lsu_size_t        req_size;
  lsu_size_t        in_size;
  logic             req_signed;
  logic [1:0]       req_lo;
  logic [CNT_W-1:0] wait_cnt;
  logic [3:0]       st_mask;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_val;
  logic             unused_addr_bits;

  assign in_size          = access_size(is_store, funct3);
  assign stall            = lsu_req & ~lsu_done;
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  // Store lanes come from the live request; load extension uses the fields captured at issue.
  lsu_align u_align (
    .st_size    (in_size),
    .st_lo      (addr[1:0]),
    .store_data (store_data),
    .st_mask    (st_mask),
    .st_wdata   (st_wdata),
    .ld_size    (req_size),
    .ld_signed  (req_signed),
    .ld_lo      (req_lo),
    .rd_word    (mem_r_data),
    .ld_val     (ld_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req_size    <= SZ_W;
      req_signed  <= 1'b0;
      req_lo      <= 2'b00;
      wait_cnt    <= '0;
      load_data   <= '0;
      lsu_done    <= 1'b0;
      bus_err     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned  <= 1'b0;
`endif
      mem_request <= 1'b0;
      mem_we_re   <= 1'b0;
      mem_address <= '0;
      mem_w_data  <= '0;
      mem_masking <= '0;
    end else begin
      // Completion flags and the bus strobe are single-cycle pulses by default.
      lsu_done    <= 1'b0;
      bus_err     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned  <= 1'b0;
`endif
      mem_request <= 1'b0;
      mem_we_re   <= 1'b0;
      mem_address <= '0;
      mem_w_data  <= '0;
      mem_masking <= '0;
      case (state)
        S_IDLE: begin
          if (lsu_req) begin
            req_size   <= in_size;
            req_signed <= ~funct3[2];
            req_lo     <= addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
            if (is_misaligned(in_size, addr[1:0])) begin
              state      <= S_DONE;
              lsu_done   <= 1'b1;
              misaligned <= 1'b1;
              load_data  <= '0;
            end else
`endif
            begin
              state       <= S_ISSUE;
              mem_request <= 1'b1;
              mem_we_re   <= is_store;
              mem_address <= addr[ADDR_W+1:2];
              mem_w_data  <= is_store ? st_wdata : '0;
              mem_masking <= is_store ? st_mask : '0;
            end
          end
        end
        S_ISSUE: begin
          if (mem_we_re) begin
            state    <= S_DONE;
            lsu_done <= 1'b1;
          end else begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (mem_valid) begin
            state     <= S_DONE;
            lsu_done  <= 1'b1;
            load_data <= ld_val;
          end else if (wait_cnt == CNT_LAST) begin
            state     <= S_DONE;
            lsu_done  <= 1'b1;
            bus_err   <= 1'b1;
            load_data <= '0;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomized self-checking bench for lsu_mem_initiator against a lane-arithmetic reference model.
module tb_lsu_mem_initiator;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              lsu_req;
  logic              is_store;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       store_data;
  logic [31:0]       load_data;
  logic              lsu_done;
  logic              stall;
  logic              bus_err;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              misaligned;
`endif
  logic              mem_request;
  logic              mem_we_re;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_w_data;
  logic [3:0]        mem_masking;
  logic              mem_valid;
  logic [31:0]       mem_r_data;

  int n_tests = 0;
  int n_fail  = 0;

  int          o_req_cnt, o_req_cyc, o_done_cyc;
  logic        o_we, o_berr, o_mis, o_stall_bad;
  logic [7:0]  o_addr;
  logic [3:0]  o_mask;
  logic [31:0] o_wdata, o_load;

  typedef struct packed {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] w;
    logic [7:0]  ea;
    logic [3:0]  em;
    logic [31:0] ev;
  } vec_t;

  vec_t dvec [6];

  lsu_mem_initiator #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .lsu_req     (lsu_req),
    .is_store    (is_store),
    .funct3      (funct3),
    .addr        (addr),
    .store_data  (store_data),
    .load_data   (load_data),
    .lsu_done    (lsu_done),
    .stall       (stall),
    .bus_err     (bus_err),
`ifdef LSU_MISALIGN_TRAP_EN
    .misaligned  (misaligned),
`endif
    .mem_request (mem_request),
    .mem_we_re   (mem_we_re),
    .mem_address (mem_address),
    .mem_w_data  (mem_w_data),
    .mem_masking (mem_masking),
    .mem_valid   (mem_valid),
    .mem_r_data  (mem_r_data)
  );

  always #5 clk = ~clk;

  // One core access; the bench plays a memory that raises mem_valid vdelay cycles after the
  // request cycle (vdelay < 0: never). Cycle 1 is the cycle after the edge that samples lsu_req.
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input int vdelay, input logic [31:0] rd_word);
    int valid_at;
    valid_at    = -100;
    o_req_cnt   = 0;
    o_req_cyc   = -1;
    o_done_cyc  = -1;
    o_we        = 1'b0;
    o_addr      = '0;
    o_mask      = '0;
    o_wdata     = '0;
    o_load      = '0;
    o_berr      = 1'b0;
    o_mis       = 1'b0;
    o_stall_bad = 1'b0;
    @(negedge clk);
    lsu_req = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; mem_valid = 1'b0;
    for (int c = 1; c <= 60 && o_done_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (mem_request) begin
        o_req_cnt++;
        if (o_req_cnt == 1) begin
          o_req_cyc = c; o_we = mem_we_re; o_addr = mem_address;
          o_mask = mem_masking; o_wdata = mem_w_data;
          if (!mem_we_re && vdelay >= 0) valid_at = c + vdelay;
        end
      end
      if (stall !== !lsu_done) o_stall_bad = 1'b1;
      if (lsu_done) begin
        o_done_cyc = c; o_load = load_data; o_berr = bus_err;
`ifdef LSU_MISALIGN_TRAP_EN
        o_mis = misaligned;
`endif
        lsu_req = 1'b0;
      end
      if (c == valid_at) begin
        mem_valid = 1'b1; mem_r_data = rd_word;
      end else begin
        mem_valid = 1'b0; mem_r_data = $urandom;
      end
    end
    lsu_req = 1'b0;
    if (o_done_cyc < 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    @(posedge clk); #1;
    mem_valid = 1'b0;
    if (mem_request) o_req_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; lsu_req = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; store_data = '0;
    mem_valid = 1'b0; mem_r_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (lsu_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", lsu_done); end
    n_tests++; if (mem_request !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req got %b want 0", mem_request); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_bus_err got %b want 0", bus_err); end
    n_tests++; if (load_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_load_data got %h want 0", load_data); end
    n_tests++; if ({mem_we_re, mem_address, mem_w_data, mem_masking} !== '0) begin n_fail++; $display("[TB] FAIL reset_mem_bus got we=%b a=%h d=%h m=%b want all 0", mem_we_re, mem_address, mem_w_data, mem_masking); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall_idle got %b want 0", stall); end
    lsu_req = 1'b1; is_store = 1'b1; funct3 = 3'd2; addr = 32'h10;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_stall_req got %b want 1", stall); end
    @(posedge clk); #1;
    n_tests++; if (mem_request !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_blocks_req got %b want 0", mem_request); end
    lsu_req = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    dvec = '{
      '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        8'h04, 4'hF, 32'hDEADBEEF},
      '{1'b1, 3'd0, 32'h13, 32'h000000A5, 32'h0,        8'h04, 4'h8, 32'hA5A5A5A5},
      '{1'b0, 3'd0, 32'h0E, 32'h0,        32'h80FF1234, 8'h03, 4'h0, 32'hFFFFFFFF},
      '{1'b0, 3'd4, 32'h0E, 32'h0,        32'h80FF1234, 8'h03, 4'h0, 32'h000000FF},
      '{1'b0, 3'd1, 32'h12, 32'h0,        32'h8001FFFF, 8'h04, 4'h0, 32'hFFFF8001},
      '{1'b0, 3'd5, 32'h12, 32'h0,        32'h8001FFFF, 8'h04, 4'h0, 32'h00008001}
    };
    for (int i = 0; i < 6; i++) begin
      run_access(dvec[i].st, dvec[i].f3, dvec[i].a, dvec[i].sd, 1, dvec[i].w);
      n_tests++; if (o_done_cyc != (dvec[i].st ? 2 : 3)) begin n_fail++; $display("[TB] FAIL dir_latency v%0d got %0d want %0d", i, o_done_cyc, dvec[i].st ? 2 : 3); end
      n_tests++; if ({o_req_cnt, o_req_cyc} != {32'd1, 32'd1}) begin n_fail++; $display("[TB] FAIL dir_req_pulse v%0d got cnt=%0d cyc=%0d want 1/1", i, o_req_cnt, o_req_cyc); end
      n_tests++; if ({o_we, o_addr, o_mask} !== {dvec[i].st, dvec[i].ea, dvec[i].em}) begin n_fail++; $display("[TB] FAIL dir_bus v%0d got we=%b a=%h m=%b want we=%b a=%h m=%b", i, o_we, o_addr, o_mask, dvec[i].st, dvec[i].ea, dvec[i].em); end
      n_tests++; if ((dvec[i].st ? o_wdata : o_load) !== dvec[i].ev) begin n_fail++; $display("[TB] FAIL dir_data v%0d got %h want %h", i, dvec[i].st ? o_wdata : o_load, dvec[i].ev); end
    end
  endtask

  task automatic test_random(input int n);
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, sd, w, v, e_wdata, e_load;
    logic [3:0]  e_mask;
    logic        e_trap, e_berr;
    int          vd, r, nbytes, e_reqs, e_done;
    for (int i = 0; i < n; i++) begin
      st = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      a = $urandom; sd = $urandom; w = $urandom;
      r = $urandom_range(0, 9);
      vd = (r < 6) ? 1 : (r == 6) ? $urandom_range(2, TIMEOUT) : (r == 7) ? TIMEOUT + 1 : (r == 8) ? -1 : 0;
      nbytes = (f3 == 0 || (!st && f3 == 4)) ? 1 : (f3 == 1 || (!st && f3 == 5)) ? 2 : 4;
      e_trap = MIS_EN && ((nbytes == 2 && a % 2 == 1) || (nbytes == 4 && a % 4 != 0));
      e_mask = !st ? 4'h0 : (nbytes == 1) ? 4'(1 << (a % 4)) : (nbytes == 2) ? ((a % 4 >= 2) ? 4'hC : 4'h3) : 4'hF;
      e_wdata = (nbytes == 1) ? (sd & 32'hFF) * 32'h01010101 : (nbytes == 2) ? (sd & 32'hFFFF) * 32'h00010001 : sd;
      if (nbytes == 1) begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
      end else if (nbytes == 2) begin
        v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
      end else begin
        v = w;
      end
      e_berr = !st && !e_trap && !(vd >= 1 && vd <= TIMEOUT);
      e_load = (e_berr || e_trap) ? 32'h0 : v;
      e_reqs = e_trap ? 0 : 1;
      e_done = e_trap ? 1 : st ? 2 : e_berr ? TIMEOUT + 2 : vd + 2;
      run_access(st, f3, a, sd, vd, w);
      n_tests++; if (o_req_cnt != e_reqs || o_done_cyc != e_done) begin n_fail++; $display("[TB] FAIL rand_timing i=%0d st=%b f3=%0d a=%h vd=%0d got reqs=%0d done=%0d want reqs=%0d done=%0d", i, st, f3, a, vd, o_req_cnt, o_done_cyc, e_reqs, e_done); end
      if (e_reqs == 1) begin
        n_tests++; if ({o_we, o_addr, o_mask} !== {st, a[9:2], e_mask} || o_req_cyc != 1) begin n_fail++; $display("[TB] FAIL rand_bus i=%0d got we=%b a=%h m=%b cyc=%0d want we=%b a=%h m=%b cyc=1", i, o_we, o_addr, o_mask, o_req_cyc, st, a[9:2], e_mask); end
      end
      if (st && !e_trap) begin
        n_tests++; if (o_wdata !== e_wdata) begin n_fail++; $display("[TB] FAIL rand_wdata i=%0d f3=%0d sd=%h got %h want %h", i, f3, sd, o_wdata, e_wdata); end
      end
      if (!st || e_trap) begin
        n_tests++; if (o_load !== e_load) begin n_fail++; $display("[TB] FAIL rand_load i=%0d f3=%0d a=%h w=%h got %h want %h", i, f3, a, w, o_load, e_load); end
      end
      n_tests++; if (o_berr !== e_berr) begin n_fail++; $display("[TB] FAIL rand_bus_err i=%0d got %b want %b", i, o_berr, e_berr); end
`ifdef LSU_MISALIGN_TRAP_EN
      n_tests++; if (o_mis !== e_trap) begin n_fail++; $display("[TB] FAIL rand_misaligned i=%0d got %b want %b", i, o_mis, e_trap); end
`endif
      n_tests++; if (o_stall_bad !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_stall i=%0d got bad=%b want 0", i, o_stall_bad); end
    end
  endtask

  task automatic test_timeout();
    int vds [4] = '{-1, 0, TIMEOUT, TIMEOUT + 1};
    logic [31:0] w;
    logic        eb;
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      eb = !(vds[i] >= 1 && vds[i] <= TIMEOUT);
      run_access(1'b0, 3'd2, 32'h40, 32'h0, vds[i], w);
      n_tests++; if (o_done_cyc != TIMEOUT + 2) begin n_fail++; $display("[TB] FAIL timeout_done vd=%0d got %0d want %0d", vds[i], o_done_cyc, TIMEOUT + 2); end
      n_tests++; if (o_berr !== eb) begin n_fail++; $display("[TB] FAIL timeout_bus_err vd=%0d got %b want %b", vds[i], o_berr, eb); end
      n_tests++; if (o_load !== (eb ? 32'h0 : w)) begin n_fail++; $display("[TB] FAIL timeout_load vd=%0d got %h want %h", vds[i], o_load, eb ? 32'h0 : w); end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] w;
    w = 32'h11223344;
    run_access(1'b0, 3'd2, 32'h02, 32'h0, 1, w);
    n_tests++; if (o_req_cnt != (MIS_EN ? 0 : 1) || o_done_cyc != (MIS_EN ? 1 : 3)) begin n_fail++; $display("[TB] FAIL mis_lw_timing got reqs=%0d done=%0d want reqs=%0d done=%0d", o_req_cnt, o_done_cyc, MIS_EN ? 0 : 1, MIS_EN ? 1 : 3); end
    n_tests++; if (o_load !== (MIS_EN ? 32'h0 : w)) begin n_fail++; $display("[TB] FAIL mis_lw_load got %h want %h", o_load, MIS_EN ? 32'h0 : w); end
`ifdef LSU_MISALIGN_TRAP_EN
    n_tests++; if (o_mis !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_lw_flag got %b want 1", o_mis); end
`endif
    run_access(1'b1, 3'd1, 32'h01, 32'h0000BEEF, 1, 32'h0);
    n_tests++; if (o_req_cnt != (MIS_EN ? 0 : 1) || o_done_cyc != (MIS_EN ? 1 : 2)) begin n_fail++; $display("[TB] FAIL mis_sh_timing got reqs=%0d done=%0d", o_req_cnt, o_done_cyc); end
    n_tests++; if (!MIS_EN && (o_mask !== 4'h3 || o_wdata !== 32'hBEEFBEEF)) begin n_fail++; $display("[TB] FAIL mis_sh_bus got m=%b d=%h want 0011/beefbeef", o_mask, o_wdata); end
  endtask

  task automatic test_reset_mid();
    int dones, reqs;
    logic [31:0] w;
    @(negedge clk);
    lsu_req = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h44;
    @(posedge clk); #1;
    rst = 1'b1; lsu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (mem_request !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_drops_req got %b want 0", mem_request); end
    @(negedge clk);
    lsu_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; lsu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_valid = 1'b1; mem_r_data = $urandom;
    dones = 0; reqs = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      mem_valid = 1'b0;
      dones += int'(lsu_done); reqs += int'(mem_request);
    end
    n_tests++; if (dones != 0) begin n_fail++; $display("[TB] FAIL rst_late_valid_done got %0d pulses want 0", dones); end
    n_tests++; if (reqs != 0) begin n_fail++; $display("[TB] FAIL rst_idle_req got %0d pulses want 0", reqs); end
    w = $urandom;
    run_access(1'b0, 3'd2, 32'h48, 32'h0, 1, w);
    n_tests++; if (o_load !== w || o_done_cyc != 3) begin n_fail++; $display("[TB] FAIL rst_recover got %h at %0d want %h at 3", o_load, o_done_cyc, w); end
  endtask

  task automatic test_back_to_back();
    int r1, r2, d1, d2;
    r1 = -1; r2 = -1; d1 = -1; d2 = -1;
    @(negedge clk);
    lsu_req = 1'b1; is_store = 1'b1; funct3 = 3'd2; addr = 32'h20; store_data = $urandom;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (mem_request) begin if (r1 < 0) r1 = c; else if (r2 < 0) r2 = c; end
      if (lsu_done) begin if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c; end
    end
    lsu_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if (r1 != 1 || r2 != 4) begin n_fail++; $display("[TB] FAIL b2b_req_cycles got %0d,%0d want 1,4", r1, r2); end
    n_tests++; if (d1 != 2 || d2 != 5) begin n_fail++; $display("[TB] FAIL b2b_done_cycles got %0d,%0d want 2,5", d1, d2); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_random(40);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
